// File: rtl/reservation_station_pkg.sv
// Shared widths, instruction codes and payload types for the reservation station.
// Optional feature macro used by the top: RS_PERF_CNT_EN.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE           = 16;
    localparam int unsigned RS_IDX_W          = 4;
    localparam int unsigned CNT_W             = RS_IDX_W + 1;
    localparam int unsigned INST_TYPE_WIDTH   = 6;
    localparam int unsigned ROB_WIDTH         = 5;
    localparam int unsigned INSTRUCTION_WIDTH = 32;

    localparam logic [ROB_WIDTH-1:0] NULL    = '0;
    localparam logic                 ENABLE  = 1'b1;
    localparam logic                 DISABLE = 1'b0;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_NOP  = 6'd0,
        INST_ADD  = 6'd1,
        INST_SUB  = 6'd2,
        INST_AND  = 6'd3,
        INST_OR   = 6'd4,
        INST_XOR  = 6'd5,
        INST_SLL  = 6'd6,
        INST_SRL  = 6'd7,
        INST_SRA  = 6'd8,
        INST_SLT  = 6'd9,
        INST_SLTU = 6'd10,
        INST_ADDI = 6'd11,
        INST_LUI  = 6'd12,
        INST_JAL  = 6'd13,
        INST_JALR = 6'd14,
        INST_BEQ  = 6'd15,
        INST_BNE  = 6'd16,
        INST_BLT  = 6'd17,
        INST_BGE  = 6'd18
    } inst_type_e;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]         q;
        logic [INSTRUCTION_WIDTH-1:0] v;
    } operand_t;

    typedef struct packed {
        logic                         en;
        logic [ROB_WIDTH-1:0]         tag;
        logic [INSTRUCTION_WIDTH-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic [INST_TYPE_WIDTH-1:0]   inst_type;
        operand_t                     j;
        operand_t                     k;
        logic [INSTRUCTION_WIDTH-1:0] a;
        logic [INSTRUCTION_WIDTH-1:0] pc;
        logic [ROB_WIDTH-1:0]         dest;
    } entry_t;

    // Resolve a pending operand from the broadcast buses; the ALU bus wins a tie.
    function automatic operand_t rs_capture(operand_t op, cdb_t alu, cdb_t lsb);
        rs_capture = op;
        if (op.q != NULL) begin
            if (alu.en && alu.tag == op.q) begin
                rs_capture.q = NULL;
                rs_capture.v = alu.data;
            end else if (lsb.en && lsb.tag == op.q) begin
                rs_capture.q = NULL;
                rs_capture.v = lsb.data;
            end
        end
    endfunction

endpackage

// File: rtl/reservation_station_priority_sel.sv
// Lowest-index set-bit finder used for free-slot search and ready-entry selection.
module rs_priority_sel #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found_c,
    output logic [IDX_W-1:0] o_idx_c
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_found_c = 1'b0;
        o_idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found_c = 1'b1;
                o_idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: operand wakeup, in-order-by-slot issue, early full.
// Define RS_PERF_CNT_EN to add the issue and full-cycle performance counters.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear_in,
    input  logic                         dispatch_en_in,
    input  logic [INST_TYPE_WIDTH-1:0]   dispatch_inst_type_in,
    input  logic [INSTRUCTION_WIDTH-1:0] dispatch_vj_in,
    input  logic [INSTRUCTION_WIDTH-1:0] dispatch_vk_in,
    input  logic [ROB_WIDTH-1:0]         dispatch_qj_in,
    input  logic [ROB_WIDTH-1:0]         dispatch_qk_in,
    input  logic [INSTRUCTION_WIDTH-1:0] dispatch_A_in,
    input  logic [ROB_WIDTH-1:0]         dispatch_dest_in,
    input  logic [INSTRUCTION_WIDTH-1:0] dispatch_pc_in,
    output logic                         full_out,
    input  logic                         alu_cdb_en_in,
    input  logic [ROB_WIDTH-1:0]         alu_cdb_robnum_in,
    input  logic [INSTRUCTION_WIDTH-1:0] alu_cdb_data_in,
    input  logic                         lsb_cdb_en_in,
    input  logic [ROB_WIDTH-1:0]         lsb_cdb_robnum_in,
    input  logic [INSTRUCTION_WIDTH-1:0] lsb_cdb_data_in,
    output logic                         alu_en_out,
    output logic [INST_TYPE_WIDTH-1:0]   alu_inst_type_out,
    output logic [INSTRUCTION_WIDTH-1:0] alu_vj_out,
    output logic [INSTRUCTION_WIDTH-1:0] alu_vk_out,
    output logic [INSTRUCTION_WIDTH-1:0] alu_A_out,
    output logic [INSTRUCTION_WIDTH-1:0] alu_pc_out,
    output logic [ROB_WIDTH-1:0]         alu_dest_out
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_issue_cnt_out,
    output logic [31:0]                  perf_full_cnt_out
`endif
);

    logic [RS_SIZE-1:0]  r_busy;
    entry_t              r_ent [RS_SIZE];
    logic [CNT_W-1:0]    r_count;

    logic [RS_SIZE-1:0]  w_ready;
    logic                w_free_found;
    logic [RS_IDX_W-1:0] w_free_idx;
    logic                w_iss_found;
    logic [RS_IDX_W-1:0] w_iss_idx;
    logic                w_disp_ok;
    logic [CNT_W-1:0]    w_count_nxt;
    cdb_t                w_alu_cdb;
    cdb_t                w_lsb_cdb;
    entry_t              w_new;

    assign w_alu_cdb = {alu_cdb_en_in, alu_cdb_robnum_in, alu_cdb_data_in};
    assign w_lsb_cdb = {lsb_cdb_en_in, lsb_cdb_robnum_in, lsb_cdb_data_in};

    // Incoming entry with same-cycle broadcast forwarding applied.
    always_comb begin
        w_new           = '0;
        w_new.inst_type = dispatch_inst_type_in;
        w_new.j         = rs_capture({dispatch_qj_in, dispatch_vj_in}, w_alu_cdb, w_lsb_cdb);
        w_new.k         = rs_capture({dispatch_qk_in, dispatch_vk_in}, w_alu_cdb, w_lsb_cdb);
        w_new.a         = dispatch_A_in;
        w_new.pc        = dispatch_pc_in;
        w_new.dest      = dispatch_dest_in;
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            w_ready[i] = r_busy[i] && (r_ent[i].j.q == NULL) && (r_ent[i].k.q == NULL);
        end
    end

    rs_priority_sel #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
        .i_req     (~r_busy),
        .o_found_c (w_free_found),
        .o_idx_c   (w_free_idx)
    );

    rs_priority_sel #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
        .i_req     (w_ready),
        .o_found_c (w_iss_found),
        .o_idx_c   (w_iss_idx)
    );

    assign w_disp_ok   = dispatch_en_in && w_free_found;
    assign w_count_nxt = r_count + CNT_W'(w_disp_ok) - CNT_W'(w_iss_found);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy            <= '0;
            r_count           <= '0;
            full_out          <= DISABLE;
            alu_en_out        <= DISABLE;
            alu_inst_type_out <= '0;
            alu_vj_out        <= '0;
            alu_vk_out        <= '0;
            alu_A_out         <= '0;
            alu_pc_out        <= '0;
            alu_dest_out      <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                r_ent[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy     <= '0;
                r_count    <= '0;
                full_out   <= DISABLE;
                alu_en_out <= DISABLE;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (r_busy[i]) begin
                        r_ent[i].j <= rs_capture(r_ent[i].j, w_alu_cdb, w_lsb_cdb);
                        r_ent[i].k <= rs_capture(r_ent[i].k, w_alu_cdb, w_lsb_cdb);
                    end
                end
                alu_en_out <= w_iss_found;
                if (w_iss_found) begin
                    r_busy[w_iss_idx] <= DISABLE;
                    alu_inst_type_out <= r_ent[w_iss_idx].inst_type;
                    alu_vj_out        <= r_ent[w_iss_idx].j.v;
                    alu_vk_out        <= r_ent[w_iss_idx].k.v;
                    alu_A_out         <= r_ent[w_iss_idx].a;
                    alu_pc_out        <= r_ent[w_iss_idx].pc;
                    alu_dest_out      <= r_ent[w_iss_idx].dest;
                end
                // The issuing slot is still busy here, so dispatch never lands on it.
                if (w_disp_ok) begin
                    r_busy[w_free_idx] <= ENABLE;
                    r_ent[w_free_idx]  <= w_new;
                end
                r_count  <= w_count_nxt;
                full_out <= (w_count_nxt >= CNT_W'(RS_SIZE - 1));
            end
        end
    end

`ifdef RS_PERF_CNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_issue_cnt_out <= '0;
            perf_full_cnt_out  <= '0;
        end else if (rdy_in) begin
            if (!clear_in && w_iss_found) begin
                perf_issue_cnt_out <= perf_issue_cnt_out + 32'd1;
            end
            if (full_out) begin
                perf_full_cnt_out <= perf_full_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table plus multi-cycle corner sequences.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        dispatch_en_in;
    logic [5:0]  dispatch_inst_type_in;
    logic [31:0] dispatch_vj_in, dispatch_vk_in, dispatch_A_in, dispatch_pc_in;
    logic [4:0]  dispatch_qj_in, dispatch_qk_in, dispatch_dest_in;
    logic        full_out;
    logic        alu_cdb_en_in, lsb_cdb_en_in;
    logic [4:0]  alu_cdb_robnum_in, lsb_cdb_robnum_in;
    logic [31:0] alu_cdb_data_in, lsb_cdb_data_in;
    logic        alu_en_out;
    logic [5:0]  alu_inst_type_out;
    logic [31:0] alu_vj_out, alu_vk_out, alu_A_out, alu_pc_out;
    logic [4:0]  alu_dest_out;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .dispatch_en_in(dispatch_en_in), .dispatch_inst_type_in(dispatch_inst_type_in),
        .dispatch_vj_in(dispatch_vj_in), .dispatch_vk_in(dispatch_vk_in),
        .dispatch_qj_in(dispatch_qj_in), .dispatch_qk_in(dispatch_qk_in),
        .dispatch_A_in(dispatch_A_in), .dispatch_dest_in(dispatch_dest_in),
        .dispatch_pc_in(dispatch_pc_in), .full_out(full_out),
        .alu_cdb_en_in(alu_cdb_en_in), .alu_cdb_robnum_in(alu_cdb_robnum_in),
        .alu_cdb_data_in(alu_cdb_data_in), .lsb_cdb_en_in(lsb_cdb_en_in),
        .lsb_cdb_robnum_in(lsb_cdb_robnum_in), .lsb_cdb_data_in(lsb_cdb_data_in),
        .alu_en_out(alu_en_out), .alu_inst_type_out(alu_inst_type_out),
        .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out), .alu_A_out(alu_A_out),
        .alu_pc_out(alu_pc_out), .alu_dest_out(alu_dest_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  typ;
        logic [31:0] vj;
        logic [4:0]  qj;
        logic [31:0] vk;
        logic [4:0]  qk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        alu_en;
        logic [4:0]  alu_tag;
        logic [31:0] alu_data;
        logic        lsb_en;
        logic [4:0]  lsb_tag;
        logic [31:0] lsb_data;
        logic [31:0] exp_vj;
        logic [31:0] exp_vk;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dispatch_en_in = 1'b0;
        alu_cdb_en_in  = 1'b0;
        lsb_cdb_en_in  = 1'b0;
        clear_in       = 1'b0;
    endtask

    task automatic disp(input logic [5:0] t, input logic [31:0] vj, input logic [4:0] qj,
                        input logic [31:0] vk, input logic [4:0] qk, input logic [31:0] a,
                        input logic [31:0] pc, input logic [4:0] dest);
        dispatch_en_in        = 1'b1;
        dispatch_inst_type_in = t;
        dispatch_vj_in        = vj;
        dispatch_qj_in        = qj;
        dispatch_vk_in        = vk;
        dispatch_qk_in        = qk;
        dispatch_A_in         = a;
        dispatch_pc_in        = pc;
        dispatch_dest_in      = dest;
    endtask

    task automatic alu_bc(input logic [4:0] tag, input logic [31:0] data);
        alu_cdb_en_in = 1'b1; alu_cdb_robnum_in = tag; alu_cdb_data_in = data;
    endtask

    task automatic lsb_bc(input logic [4:0] tag, input logic [31:0] data);
        lsb_cdb_en_in = 1'b1; lsb_cdb_robnum_in = tag; lsb_cdb_data_in = data;
    endtask

    initial begin
        // typ, vj, qj, vk, qk, A, pc, dest, alu{en,tag,data}, lsb{en,tag,data}, exp_vj, exp_vk
        vecs[0] = '{6'd1,  32'd5,      5'd0, 32'd7,     5'd0, 32'd0,    32'h1000, 5'd3,
                    1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      32'd5,      32'd7};
        vecs[1] = '{6'd2,  32'h11,     5'd0, 32'h999,   5'd6, 32'h4,    32'h1004, 5'd8,
                    1'b0, 5'd0, 32'd0,      1'b1, 5'd6, 32'hAA,     32'h11,     32'hAA};
        vecs[2] = '{6'd15, 32'h333,    5'd9, 32'h44,    5'd0, 32'hFFF0, 32'h1008, 5'd10,
                    1'b1, 5'd9, 32'h111,    1'b1, 5'd9, 32'h222,    32'h111,    32'h44};
        vecs[3] = '{6'd5,  32'h0,      5'd2, 32'h0,     5'd3, 32'h8,    32'h100C, 5'd31,
                    1'b1, 5'd2, 32'h55,     1'b1, 5'd3, 32'h66,     32'h55,     32'h66};
        vecs[4] = '{6'd11, 32'hDEAD,   5'd0, 32'hBEEF,  5'd0, 32'h7,    32'h1010, 5'd1,
                    1'b1, 5'd0, 32'h9999,   1'b1, 5'd0, 32'h8888,   32'hDEAD,   32'hBEEF};

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        disp(6'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        dispatch_en_in = 1'b0;
        alu_cdb_robnum_in = '0; alu_cdb_data_in = '0;
        lsb_cdb_robnum_in = '0; lsb_cdb_data_in = '0;
        #12;
        chk("reset_en", 32'(alu_en_out), 32'd0);
        chk("reset_full", 32'(full_out), 32'd0);
        chk("reset_vj", alu_vj_out, 32'd0);
        chk("reset_dest", 32'(alu_dest_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        step();

        // Single-instruction vectors, including dispatch-time forwarding.
        for (int i = 0; i < 5; i++) begin
            disp(vecs[i].typ, vecs[i].vj, vecs[i].qj, vecs[i].vk, vecs[i].qk,
                 vecs[i].a, vecs[i].pc, vecs[i].dest);
            alu_cdb_en_in = vecs[i].alu_en; alu_cdb_robnum_in = vecs[i].alu_tag;
            alu_cdb_data_in = vecs[i].alu_data;
            lsb_cdb_en_in = vecs[i].lsb_en; lsb_cdb_robnum_in = vecs[i].lsb_tag;
            lsb_cdb_data_in = vecs[i].lsb_data;
            step();
            idle();
            chk($sformatf("vec%0d_en_early", i), 32'(alu_en_out), 32'd0);
            step();
            chk($sformatf("vec%0d_en", i), 32'(alu_en_out), 32'd1);
            chk($sformatf("vec%0d_type", i), 32'(alu_inst_type_out), 32'(vecs[i].typ));
            chk($sformatf("vec%0d_vj", i), alu_vj_out, vecs[i].exp_vj);
            chk($sformatf("vec%0d_vk", i), alu_vk_out, vecs[i].exp_vk);
            chk($sformatf("vec%0d_A", i), alu_A_out, vecs[i].a);
            chk($sformatf("vec%0d_pc", i), alu_pc_out, vecs[i].pc);
            chk($sformatf("vec%0d_dest", i), 32'(alu_dest_out), 32'(vecs[i].dest));
            step();
            chk($sformatf("vec%0d_pulse", i), 32'(alu_en_out), 32'd0);
            chk($sformatf("vec%0d_hold_vj", i), alu_vj_out, vecs[i].exp_vj);
        end

        // Wakeup from the ALU bus two cycles after dispatch.
        disp(6'd1, 32'hFFFF, 5'd4, 32'h10, 5'd0, 32'd0, 32'h2000, 5'd7);
        step(); idle();
        chk("wake_wait0", 32'(alu_en_out), 32'd0);
        step();
        chk("wake_wait1", 32'(alu_en_out), 32'd0);
        alu_bc(5'd4, 32'h1234);
        step(); idle();
        chk("wake_capture_edge", 32'(alu_en_out), 32'd0);
        step();
        chk("wake_en", 32'(alu_en_out), 32'd1);
        chk("wake_vj", alu_vj_out, 32'h1234);
        chk("wake_vk", alu_vk_out, 32'h10);
        chk("wake_dest", 32'(alu_dest_out), 32'd7);
        step();
        chk("wake_pulse", 32'(alu_en_out), 32'd0);

        // Fill to 15 entries with pending tags 1..15, then release entry 0.
        for (int i = 0; i < 15; i++) begin
            disp(6'd1, 32'd0, 5'(i + 1), 32'h100 + 32'(i), 5'd0, 32'd0, 32'd0, 5'(i + 16));
            step();
            if (i == 13) chk("fill14_full", 32'(full_out), 32'd0);
        end
        idle();
        chk("fill15_full", 32'(full_out), 32'd1);
        chk("fill15_en", 32'(alu_en_out), 32'd0);
        alu_bc(5'd1, 32'hBEEF);
        step(); idle();
        chk("fill_capture_full", 32'(full_out), 32'd1);
        chk("fill_capture_en", 32'(alu_en_out), 32'd0);
        step();
        chk("fill_issue_en", 32'(alu_en_out), 32'd1);
        chk("fill_issue_vj", alu_vj_out, 32'hBEEF);
        chk("fill_issue_vk", alu_vk_out, 32'h100);
        chk("fill_issue_dest", 32'(alu_dest_out), 32'd16);
        chk("fill_issue_full", 32'(full_out), 32'd0);
        step();
        chk("fill_pulse", 32'(alu_en_out), 32'd0);

        clear_in = 1'b1;
        step(); idle();
        chk("clear1_full", 32'(full_out), 32'd0);
        chk("clear1_en", 32'(alu_en_out), 32'd0);

        // Entries 2 and 5 share tag 20 and wake together; lower index goes first.
        disp(6'd1, 32'd0, 5'd21, 32'd0, 5'd0, 32'd0, 32'd0, 5'd10); step();
        disp(6'd1, 32'd0, 5'd22, 32'd0, 5'd0, 32'd0, 32'd0, 5'd11); step();
        disp(6'd1, 32'd0, 5'd20, 32'd2, 5'd0, 32'd0, 32'd0, 5'd12); step();
        disp(6'd1, 32'd0, 5'd23, 32'd0, 5'd0, 32'd0, 32'd0, 5'd13); step();
        disp(6'd1, 32'd0, 5'd24, 32'd0, 5'd0, 32'd0, 32'd0, 5'd14); step();
        disp(6'd1, 32'd0, 5'd20, 32'd5, 5'd0, 32'd0, 32'd0, 5'd15); step();
        idle();
        lsb_bc(5'd20, 32'h77);
        step(); idle();
        chk("order_capture_en", 32'(alu_en_out), 32'd0);
        step();
        chk("order_first_en", 32'(alu_en_out), 32'd1);
        chk("order_first_dest", 32'(alu_dest_out), 32'd12);
        chk("order_first_vj", alu_vj_out, 32'h77);
        chk("order_first_vk", alu_vk_out, 32'd2);
        step();
        chk("order_second_en", 32'(alu_en_out), 32'd1);
        chk("order_second_dest", 32'(alu_dest_out), 32'd15);
        chk("order_second_vk", alu_vk_out, 32'd5);
        step();
        chk("order_done_en", 32'(alu_en_out), 32'd0);

        // Bring occupancy to 10, ready entry 0, then flush with a same-cycle dispatch.
        for (int i = 0; i < 6; i++) begin
            disp(6'd1, 32'd0, 5'(25 + i), 32'd0, 5'd0, 32'd0, 32'd0, 5'd2);
            step();
        end
        idle();
        chk("flush10_full", 32'(full_out), 32'd0);
        alu_bc(5'd21, 32'h1);
        step(); idle();
        clear_in = 1'b1;
        disp(6'd1, 32'd9, 5'd0, 32'd9, 5'd0, 32'd0, 32'd0, 5'd9);
        step(); idle();
        chk("flush_en", 32'(alu_en_out), 32'd0);
        chk("flush_full", 32'(full_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            alu_bc(5'(22 + i), 32'h5);
            step(); idle();
            chk($sformatf("flush_quiet%0d", i), 32'(alu_en_out), 32'd0);
        end

        // rdy_in low freezes state and outputs.
        disp(6'd3, 32'h31, 5'd0, 32'h32, 5'd0, 32'd0, 32'd0, 5'd9);
        step(); idle();
        rdy_in = 1'b0;
        step(); step();
        chk("rdy_freeze_en0", 32'(alu_en_out), 32'd0);
        rdy_in = 1'b1;
        step();
        chk("rdy_issue_en", 32'(alu_en_out), 32'd1);
        chk("rdy_issue_dest", 32'(alu_dest_out), 32'd9);
        rdy_in = 1'b0;
        step();
        chk("rdy_hold_en", 32'(alu_en_out), 32'd1);
        rdy_in = 1'b1;
        step();
        chk("rdy_release_en", 32'(alu_en_out), 32'd0);
        rdy_in = 1'b0;
        disp(6'd3, 32'h1, 5'd0, 32'h2, 5'd0, 32'd0, 32'd0, 5'd8);
        step(); idle();
        rdy_in = 1'b1;
        step(); step();
        chk("rdy_drop_dispatch", 32'(alu_en_out), 32'd0);

        // Asynchronous reset in the middle of an issue cycle.
        disp(6'd1, 32'h42, 5'd0, 32'h43, 5'd0, 32'd0, 32'd0, 5'd4);
        step(); idle();
        step();
        chk("arst_pre_en", 32'(alu_en_out), 32'd1);
        #3;
        rst_in = 1'b1;
        #1;
        chk("arst_en", 32'(alu_en_out), 32'd0);
        chk("arst_vj", alu_vj_out, 32'd0);
        chk("arst_full", 32'(full_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        step();
        chk("arst_after_en", 32'(alu_en_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
